// File: rtl/frame_checker_mc.sv
// Multi-channel AXIS frame checker: per-channel frame, lost, out-of-order and byte counters.
// Optional feature macro: FRAME_CHECKER_MC_BYTES_EN (per-channel byte counters).
module frame_checker_mc #(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 3,
  parameter int SEQ_OFFSET = 42
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    ready,
  input  logic                    start,
  input  logic                    stop,
  input  logic [ID_WIDTH-1:0]     result_sel,
  output logic [127:0]            result,
  input  logic [DATA_WIDTH-1:0]   axis_s_data,
  input  logic [DATA_WIDTH/8-1:0] axis_s_keep,
  input  logic                    axis_s_last,
  input  logic [DATA_WIDTH/8-1:0] axis_s_user,
  input  logic [ID_WIDTH-1:0]     axis_s_id,
  input  logic                    axis_s_valid,
  output logic                    axis_s_ready
);
  localparam int NUM_CH = 1 << ID_WIDTH;
  localparam int KW     = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                     state_q;
  logic                       ready_q, sready_q, in_frame_q, cnt_q;
  logic [ID_WIDTH-1:0]        ch_q;
  logic [NUM_CH-1:0][31:0]    frames_q, lost_q, ooo_q, exp_q;
  logic [NUM_CH-1:0]          seen_q;
  logic [127:0]               result_q;

  logic                acc, first, clear, cnt_first, counted, in_frame_d, seq_ok;
  logic [ID_WIDTH-1:0] ch;
  logic [31:0]         seq, diff, lost_new;
  logic [32:0]         lost_sum;
  logic                unused_bits;

  assign acc        = axis_s_valid & sready_q;
  assign first      = ~in_frame_q;
  assign clear      = (state_q == IDLE) & start;
  assign cnt_first  = acc & first & (state_q == RUN);
  assign counted    = acc & (first ? (state_q == RUN) : cnt_q);
  assign ch         = first ? axis_s_id : ch_q;
  assign in_frame_d = acc ? ~axis_s_last : in_frame_q;
  assign seq_ok     = &axis_s_keep[SEQ_OFFSET +: 4];

  // Sequence number is big-endian: byte SEQ_OFFSET lands in seq[31:24].
  always_comb begin
    seq = '0;
    for (int i = 0; i < 4; i++) seq[31-8*i -: 8] = axis_s_data[8*(SEQ_OFFSET+i) +: 8];
  end

  assign diff     = seq - exp_q[ch];
  assign lost_sum = {1'b0, lost_q[ch]} + {1'b0, diff};
  assign lost_new = lost_sum[32] ? 32'hFFFF_FFFF : lost_sum[31:0];

  assign unused_bits = ^{axis_s_user, axis_s_keep, axis_s_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      sready_q <= 1'b0;
    end else begin
      sready_q <= 1'b1;
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          ready_q <= 1'b0;
        end
        // A beat accepted alongside stop decides whether a frame is still open.
        RUN: if (stop) begin
          if (in_frame_d) state_q <= DRAIN;
          else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        DRAIN: if (acc && axis_s_last) begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame_q <= 1'b0;
      cnt_q      <= 1'b0;
      ch_q       <= '0;
    end else begin
      in_frame_q <= in_frame_d;
      if (acc && first) begin
        cnt_q <= (state_q == RUN);
        ch_q  <= axis_s_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_q <= '0;
      lost_q   <= '0;
      ooo_q    <= '0;
      exp_q    <= '0;
      seen_q   <= '0;
    end else if (clear) begin
      frames_q <= '0;
      lost_q   <= '0;
      ooo_q    <= '0;
      exp_q    <= '0;
      seen_q   <= '0;
    end else begin
      if (counted && axis_s_last && frames_q[ch] != 32'hFFFF_FFFF)
        frames_q[ch] <= frames_q[ch] + 32'd1;
      if (cnt_first && seq_ok) begin
        if (!seen_q[ch]) begin
          seen_q[ch] <= 1'b1;
          exp_q[ch]  <= seq + 32'd1;
        end else if (diff == 32'd0) begin
          exp_q[ch] <= seq + 32'd1;
        end else if (!diff[31]) begin
          lost_q[ch] <= lost_new;
          exp_q[ch]  <= seq + 32'd1;
        end else if (ooo_q[ch] != 32'hFFFF_FFFF) begin
          ooo_q[ch] <= ooo_q[ch] + 32'd1;
        end
      end
    end
  end

  logic [31:0] bytes_sel;
`ifdef FRAME_CHECKER_MC_BYTES_EN
  logic [NUM_CH-1:0][31:0] bytes_q;
  logic [31:0]             pc;
  logic [32:0]             bytes_sum;

  always_comb begin
    pc = '0;
    for (int i = 0; i < KW; i++) pc = pc + {31'd0, axis_s_keep[i]};
  end

  assign bytes_sum = {1'b0, bytes_q[ch]} + {1'b0, pc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       bytes_q <= '0;
    else if (clear)   bytes_q <= '0;
    else if (counted) bytes_q[ch] <= bytes_sum[32] ? 32'hFFFF_FFFF : bytes_sum[31:0];
  end

  assign bytes_sel = bytes_q[result_sel];
`else
  assign bytes_sel = 32'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_q <= '0;
    else        result_q <= {frames_q[result_sel], lost_q[result_sel], ooo_q[result_sel], bytes_sel};
  end

  assign ready        = ready_q;
  assign axis_s_ready = sready_q;
  assign result       = result_q;
endmodule

// File: tb/tb_frame_checker_mc.sv
// Directed + randomized bench for frame_checker_mc with a frame-level counter model.
module tb_frame_checker_mc;
  localparam int DW = 512, IW = 3, OFF = 42, KW = DW / 8, NCH = 1 << IW;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic          ready, axis_s_ready, last = 1'b0, valid = 1'b0;
  logic [IW-1:0] result_sel = '0, id = '0;
  logic [127:0]  result;
  logic [DW-1:0] data = '0;
  logic [KW-1:0] keep = '0, user = '0;

  frame_checker_mc #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .SEQ_OFFSET(OFF)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .start(start), .stop(stop),
    .result_sel(result_sel), .result(result),
    .axis_s_data(data), .axis_s_keep(keep), .axis_s_last(last), .axis_s_user(user),
    .axis_s_id(id), .axis_s_valid(valid), .axis_s_ready(axis_s_ready)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Frame-level reference: counters per channel plus whether a run is active.
  logic [31:0] m_frames[NCH], m_lost[NCH], m_ooo[NCH], m_exp[NCH];
  bit          m_seen[NCH];
  longint      m_bytes[NCH];
  bit          m_run = 1'b0;

  function automatic void m_clear();
    for (int c = 0; c < NCH; c++) begin
      m_frames[c] = 0; m_lost[c] = 0; m_ooo[c] = 0; m_exp[c] = 0;
      m_seen[c] = 1'b0; m_bytes[c] = 0;
    end
  endfunction

  function automatic void m_frame(int c, logic [31:0] seq, bit seq_chk, int nbytes);
    logic [31:0] d;
    longint      l;
    if (seq_chk) begin
      if (!m_seen[c]) begin
        m_seen[c] = 1'b1;
        m_exp[c]  = seq + 32'd1;
      end else begin
        d = seq - m_exp[c];
        if (d == 0) m_exp[c] = seq + 32'd1;
        else if (d < 32'h8000_0000) begin
          l = longint'(m_lost[c]) + longint'(d);
          m_lost[c] = (l > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : l[31:0];
          m_exp[c]  = seq + 32'd1;
        end else if (m_ooo[c] != 32'hFFFF_FFFF) m_ooo[c] = m_ooo[c] + 32'd1;
      end
    end
    if (m_frames[c] != 32'hFFFF_FFFF) m_frames[c] = m_frames[c] + 32'd1;
    m_bytes[c] += nbytes;
  endfunction

  function automatic logic [31:0] m_bytes_out(int c);
`ifdef FRAME_CHECKER_MC_BYTES_EN
    return (m_bytes[c] > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_bytes[c][31:0];
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [IW-1:0] bid, input logic [31:0] seq, input int kb,
                           input bit lst, input bit stp);
    for (int w = 0; w < DW / 32; w++) data[32*w +: 32] = $urandom;
    for (int i = 0; i < 4; i++) data[8*(OFF+i) +: 8] = seq[31-8*i -: 8];
    keep = '0;
    for (int i = 0; i < kb; i++) keep[i] = 1'b1;
    user  = {$urandom, $urandom};
    id    = bid;
    last  = lst;
    stop  = stp;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    last  = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic send_frame(input int c, input logic [31:0] seq, input int nb, input int kb1);
    bit counted;
    int sum;
    counted = m_run;
    sum = 0;
    for (int b = 1; b <= nb; b++) begin
      int kb;
      kb = (b == 1) ? kb1 : int'($urandom_range(1, KW));
      repeat ($urandom_range(0, 1)) tick();
      send_beat((b == 1) ? IW'(c) : IW'($urandom), seq, kb, b == nb, 1'b0);
      sum += kb;
    end
    if (counted) m_frame(c, seq, kb1 >= OFF + 4, sum);
  endtask

  task automatic start_pulse(input bit with_stop);
    start = 1'b1;
    stop  = with_stop;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    if (!m_run) begin
      m_clear();
      m_run = 1'b1;
    end
  endtask

  task automatic check_ch(input int c);
    result_sel = IW'(c);
    tick();
    tick();
    chk($sformatf("result_ch%0d", c), result, {m_frames[c], m_lost[c], m_ooo[c], m_bytes_out(c)});
  endtask

  task automatic check_all();
    for (int c = 0; c < NCH; c++) check_ch(c);
  endtask

  initial begin
    m_clear();
    #12;
    chk("rst_ready", {127'd0, ready}, 128'd1);
    chk("rst_axis_ready", {127'd0, axis_s_ready}, 128'd0);
    chk("rst_result", result, 128'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("axis_ready_after_rst", {127'd0, axis_s_ready}, 128'd1);

    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_in_idle", {127'd0, ready}, 128'd1);

    start_pulse(1'b1);
    chk("start_with_stop_runs", {127'd0, ready}, 128'd0);

    for (int s = 5; s <= 7; s++) send_frame(2, 32'(s), 1, KW);
    check_ch(2);

    send_frame(1, 32'd10, 1, KW);
    send_frame(1, 32'd11, 1, KW);
    send_frame(1, 32'd15, 1, KW);
    check_ch(1);
    send_frame(1, 32'd12, 1, KW);
    check_ch(1);
    send_frame(1, 32'd16, 1, KW);
    check_ch(1);

    send_frame(0, 32'hFFFF_FFFF, 1, KW);
    send_frame(0, 32'h0000_0000, 1, KW);
    check_ch(0);

    send_frame(3, 32'd100, 2, KW);
    send_frame(3, 32'd500, 1, OFF + 2);
    send_frame(3, 32'd101, 1, KW);
    check_ch(3);

    for (int n = 0; n < 40; n++) begin
      int          c;
      logic [31:0] s;
      c = int'($urandom_range(0, NCH - 1));
      if (m_seen[c]) s = m_exp[c] + $urandom_range(0, 8) - 32'd3;
      else s = $urandom;
      send_frame(c, s, int'($urandom_range(1, 3)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, KW)) : KW);
      if (n == 20) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    check_all();

    send_beat(3'd4, 32'd77, KW, 1'b0, 1'b0);
    send_beat(3'd6, 32'd0, KW, 1'b0, 1'b1);
    chk("drain_not_ready", {127'd0, ready}, 128'd0);
    send_beat(3'd6, 32'd0, KW, 1'b1, 1'b0);
    chk("ready_after_drain", {127'd0, ready}, 128'd1);
    m_frame(4, 32'd77, 1'b1, 3 * KW);
    m_run = 1'b0;
    send_frame(4, 32'd900, 2, KW);
    check_all();

    start_pulse(1'b0);
    send_beat(3'd5, 32'd1, KW, 1'b0, 1'b0);
    rst_n = 1'b0;
    #3;
    chk("midreset_result", result, 128'd0);
    chk("midreset_ready", {127'd0, ready}, 128'd1);
    m_clear();
    m_run = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    check_ch(5);
    start_pulse(1'b0);
    send_frame(5, 32'd9, 1, KW);
    check_ch(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frame_checker_mc.md
FRAME_CHECKER_MC -- requirements
Module: frame_checker_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 512, AXIS data width in bits, multiple of 64.
REQ-002 Parameter ID_WIDTH, default 3, channel ID width; channel count NUM_CH = 2^ID_WIDTH.
REQ-003 Parameter SEQ_OFFSET, default 42, byte offset of the 32-bit sequence number in the first beat; SEQ_OFFSET+4 <= DATA_WIDTH/8.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ready  out  1  high when idle and able to accept start.
REQ-007 start  in  1  single-cycle pulse that clears all counters and begins a run.
REQ-008 stop  in  1  single-cycle pulse that ends the run.
REQ-009 result_sel  in  ID_WIDTH  channel whose counters drive result.
REQ-010 result  out  128  {frames[127:96], lost[95:64], ooo[63:32], bytes[31:0]} of the selected channel.
REQ-011 axis_s_data/keep/last/user/id/valid  in  DATA_WIDTH/DATA_WIDTH/8/1/DATA_WIDTH/8/ID_WIDTH/1  AXIS sink; user ignored.
REQ-012 axis_s_ready  out  1  AXIS sink ready.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DRAIN; ready SHALL be 1 only in IDLE.
REQ-014 IDLE + start SHALL clear every counter, expected-sequence register and seen flag of every channel, and enter RUN on the next edge; start outside IDLE SHALL be ignored.
REQ-015 RUN + stop SHALL enter IDLE if no frame is in progress, otherwise DRAIN; DRAIN SHALL enter IDLE on acceptance of the last beat of the in-progress frame.
REQ-016 start and stop asserted together in IDLE SHALL be treated as start only; stop in IDLE SHALL be ignored.
REQ-017 axis_s_ready SHALL be 1 in every state after reset, so frames are always consumed and discarded.
REQ-018 A frame SHALL be counted only if its first beat is accepted in RUN; frames whose first beat arrives in IDLE or DRAIN SHALL not alter any counter.
REQ-019 A first beat is the first accepted beat after reset or after an accepted beat with last=1; channel is axis_s_id of the first beat.
REQ-020 The sequence number SHALL be data bytes SEQ_OFFSET..SEQ_OFFSET+3, big-endian (byte SEQ_OFFSET is MSB).
REQ-021 If keep on the first beat does not cover all four sequence bytes, the sequence check SHALL be skipped for that frame.
REQ-022 Sequence check: if channel not seen, set seen, expected=seq+1; else diff=seq-expected mod 2^32; diff==0 -> expected=seq+1; diff[31]==0 and diff!=0 -> lost+=diff, expected=seq+1; diff[31]==1 -> ooo+=1, expected unchanged.
REQ-023 frames SHALL increment by 1 on acceptance of the last beat of a counted frame.
REQ-024 All counters SHALL be 32 bits and saturate at 0xFFFFFFFF; lost SHALL use saturating addition.
REQ-025 Sequence-derived counters SHALL update on the edge that accepts the first beat; expected wraps modulo 2^32.
REQ-026 result SHALL be registered, reflecting counters of result_sel as of the previous edge (1-cycle latency).

Reset
REQ-027 While rst_n is low: state IDLE, ready=1, axis_s_ready=0, result=0, all counters, seen flags and expected values 0, first-beat tracker set to expect a first beat.
REQ-028 Reset asserted mid-frame SHALL discard the frame; the next accepted beat after release is a first beat.

Configuration
REQ-029 With macro FRAME_CHECKER_MC_BYTES_EN defined, bytes SHALL add the popcount of keep for every accepted beat of counted frames (saturating); without it, the byte counters and popcount logic SHALL be absent and result[31:0] SHALL read 0.

Verification
REQ-030 start, ch 2 frames seq 5,6,7 (1 beat each, keep all ones) -> ch2 frames=3, lost=0, ooo=0, bytes=192 (with BYTES_EN).
REQ-031 ch 1 seq 10,11,15 -> frames=3, lost=3; then seq 12 -> ooo=1, frames=4, expected stays 16.
REQ-032 ch 0 seq 0xFFFFFFFF then 0x00000000 -> lost=0, ooo=0 (wrap).
REQ-033 stop during beat 2 of 3-beat frame -> DRAIN, frame still counted, ready=1 one cycle after last beat; frame in IDLE -> no counter change.
REQ-034 Frame with keep covering only 44 bytes (SEQ_OFFSET=42) -> frames+1, lost/ooo/expected unchanged.
REQ-035 rst_n low mid-frame then released, new frame -> counters 0 before, new frame counted correctly after start.
